// File: rtl/mem_loader.sv
// mem_loader
//   Host-side initiator for the cpu external memory ports. Streams an
//   instruction image and a data image in over a valid/ready stream, lets the
//   cpu run for a programmed number of cycles, then streams the data memory
//   back out over a valid/ready stream.
//
// Ports
//   clk, arst_n                 clock, asynchronous active-low reset
//   start                       one-cycle request, only honoured while idle
//   imem_words, dmem_words,
//   run_cycles                  job parameters, sampled with start
//   in_valid/in_ready/in_data   load stream (bits [31:0] only for imem words)
//   out_valid/out_ready/out_data dump stream
//   busy, done                  job in progress / one-cycle completion pulse
//   cpu_enable                  cpu run enable
//   *_ext                       instruction memory port (write only)
//   *_ext_2, rdata_ext_2        data memory port (write during load, read during dump)
//
// State table
//   state    | meaning
//   IDLE     | waiting for start
//   LOAD_I   | accepting instruction words, one imem write per handshake
//   LOAD_D   | accepting data words, one dmem write per handshake
//   GAP      | single cycle that lets the last write pulse retire
//   RUN      | cpu_enable high while the run counter counts down
//   DUMP_RD  | dmem read request for word k
//   DUMP_CAP | read data returns and is captured into out_data
//   DUMP_OUT | out_valid high until out_ready
//   FIN      | done pulse, busy low, back to IDLE
module mem_loader #(
    parameter int IMEM_WORDS_W = 9,
    parameter int DMEM_WORDS_W = 10,
    parameter int CNT_W        = 32
) (
    input  logic                    clk,
    input  logic                    arst_n,
    input  logic                    start,
    input  logic [IMEM_WORDS_W-1:0] imem_words,
    input  logic [DMEM_WORDS_W-1:0] dmem_words,
    input  logic [CNT_W-1:0]        run_cycles,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [63:0]             in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [63:0]             out_data,
    output logic                    busy,
    output logic                    done,
    output logic                    cpu_enable,
    output logic [63:0]             addr_ext,
    output logic                    wen_ext,
    output logic                    ren_ext,
    output logic [31:0]             wdata_ext,
    output logic [63:0]             addr_ext_2,
    output logic                    wen_ext_2,
    output logic                    ren_ext_2,
    output logic [63:0]             wdata_ext_2,
    input  logic [63:0]             rdata_ext_2
);

    localparam int IDX_W = (IMEM_WORDS_W > DMEM_WORDS_W) ? IMEM_WORDS_W : DMEM_WORDS_W;

    typedef enum logic [3:0] {
        IDLE,
        LOAD_I,
        LOAD_D,
        GAP,
        RUN,
        DUMP_RD,
        DUMP_CAP,
        DUMP_OUT,
        FIN
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        run_q, run_d;
    logic [IMEM_WORDS_W-1:0] imem_words_q;
    logic [DMEM_WORDS_W-1:0] dmem_words_q;
    logic [IDX_W-1:0]        imem_last;
    logic [IDX_W-1:0]        dmem_last;
    logic                    load_i_hs;
    logic                    load_d_hs;

    assign imem_last = IDX_W'(imem_words_q) - IDX_W'(1);
    assign dmem_last = IDX_W'(dmem_words_q) - IDX_W'(1);
    assign load_i_hs = (state_q == LOAD_I) && in_valid;
    assign load_d_hs = (state_q == LOAD_D) && in_valid;

    // The instruction port is never read.
    assign ren_ext = 1'b0;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            run_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            run_q   <= run_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        run_d      = run_q;
        in_ready   = 1'b0;
        cpu_enable = 1'b0;
        ren_ext_2  = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;

        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    idx_d = '0;
                    run_d = run_cycles;
                    if (imem_words != '0) begin
                        state_d = LOAD_I;
                    end else if (dmem_words != '0) begin
                        state_d = LOAD_D;
                    end else begin
                        state_d = GAP;
                    end
                end
            end
            LOAD_I: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (idx_q == imem_last) begin
                        idx_d   = '0;
                        state_d = (dmem_words_q != '0) ? LOAD_D : GAP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            LOAD_D: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (idx_q == dmem_last) begin
                        idx_d   = '0;
                        state_d = GAP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            GAP: begin
                idx_d = '0;
                if (run_q != '0) begin
                    state_d = RUN;
                end else if (dmem_words_q != '0) begin
                    state_d = DUMP_RD;
                end else begin
                    state_d = FIN;
                end
            end
            RUN: begin
                cpu_enable = 1'b1;
                run_d      = run_q - CNT_W'(1);
                // Terminal count: this is the last enabled cycle.
                if (run_q == CNT_W'(1)) begin
                    idx_d   = '0;
                    state_d = (dmem_words_q != '0) ? DUMP_RD : FIN;
                end
            end
            DUMP_RD: begin
                ren_ext_2 = 1'b1;
                state_d   = DUMP_CAP;
            end
            DUMP_CAP: begin
                state_d = DUMP_OUT;
            end
            DUMP_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (idx_q == dmem_last) begin
                        state_d = FIN;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = DUMP_RD;
                    end
                end
            end
            FIN: begin
                busy    = 1'b0;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered memory-port datapath. Write pulses land one cycle after the
    // handshake; the dump read address is set up as DUMP_RD is entered so it
    // is valid in the same cycle as ren_ext_2.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            imem_words_q <= '0;
            dmem_words_q <= '0;
            wen_ext      <= 1'b0;
            addr_ext     <= '0;
            wdata_ext    <= '0;
            wen_ext_2    <= 1'b0;
            addr_ext_2   <= '0;
            wdata_ext_2  <= '0;
            out_data     <= '0;
        end else begin
            wen_ext   <= load_i_hs;
            wen_ext_2 <= load_d_hs;

            if ((state_q == IDLE) && start) begin
                imem_words_q <= imem_words;
                dmem_words_q <= dmem_words;
            end

            if (load_i_hs) begin
                addr_ext  <= 64'({idx_q, 2'b00});
                wdata_ext <= in_data[31:0];
            end

            if (load_d_hs) begin
                addr_ext_2  <= 64'({idx_q, 3'b000});
                wdata_ext_2 <= in_data;
            end else if (state_d == DUMP_RD) begin
                addr_ext_2 <= 64'({idx_d, 3'b000});
            end

            if (state_q == DUMP_CAP) begin
                out_data <= rdata_ext_2;
            end
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
module tb_mem_loader;
    localparam int IW = 9;
    localparam int DW = 10;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          arst_n = 1'b0;
    logic          start = 1'b0;
    logic [IW-1:0] imem_words = '0;
    logic [DW-1:0] dmem_words = '0;
    logic [CW-1:0] run_cycles = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [63:0]   in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [63:0]   out_data;
    logic          busy, done, cpu_enable;
    logic [63:0]   addr_ext;
    logic          wen_ext, ren_ext;
    logic [31:0]   wdata_ext;
    logic [63:0]   addr_ext_2;
    logic          wen_ext_2, ren_ext_2;
    logic [63:0]   wdata_ext_2;
    logic [63:0]   rdata_ext_2 = '0;

    mem_loader #(.IMEM_WORDS_W(IW), .DMEM_WORDS_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .arst_n(arst_n), .start(start),
        .imem_words(imem_words), .dmem_words(dmem_words), .run_cycles(run_cycles),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done), .cpu_enable(cpu_enable),
        .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
        .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
        .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Data memory with a 1-cycle read latency.
    logic [63:0] mem [1024];
    always @(posedge clk) begin
        if (wen_ext_2) mem[addr_ext_2[12:3]] <= wdata_ext_2;
        if (ren_ext_2) rdata_ext_2 <= mem[addr_ext_2[12:3]];
    end

    logic [296:0] all_out;
    assign all_out = {in_ready, out_valid, out_data, busy, done, cpu_enable, addr_ext, wen_ext,
                      ren_ext, wdata_ext, addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2};

    int n_tests = 0;
    int n_fail = 0;

    // Observation record, filled at the falling edge.
    logic [63:0] wi_addr[$];
    logic [31:0] wi_data[$];
    int          wi_cyc[$];
    logic [63:0] wd_addr[$];
    logic [63:0] wd_data[$];
    logic [63:0] dq[$];
    int          dq_cyc[$];
    int en_cnt, first_en, last_wr, ovl, rd_cnt, done_cnt, done_cyc;
    int stab_err, stall_cnt, busy_cnt;
    logic busy_at_done, prev_stall;
    logic [63:0] prev_data;

    logic [63:0] stim_q[$];
    int start_cyc;

    always @(negedge clk) begin
        if (arst_n) begin
            if (wen_ext) begin
                wi_addr.push_back(addr_ext); wi_data.push_back(wdata_ext);
                wi_cyc.push_back(cyc); last_wr = cyc;
            end
            if (wen_ext_2) begin
                wd_addr.push_back(addr_ext_2); wd_data.push_back(wdata_ext_2); last_wr = cyc;
            end
            if (ren_ext_2) rd_cnt++;
            if (cpu_enable) begin
                if (en_cnt == 0) first_en = cyc;
                en_cnt++;
            end
            if (int'(wen_ext) + int'(wen_ext_2) + int'(ren_ext_2) + int'(cpu_enable) > 1 || ren_ext)
                ovl++;
            if (busy) busy_cnt++;
            if (prev_stall && (!out_valid || out_data !== prev_data)) stab_err++;
            prev_stall = out_valid && !out_ready;
            if (prev_stall) stall_cnt++;
            prev_data = out_data;
            if (out_valid && out_ready) begin
                dq.push_back(out_data); dq_cyc.push_back(cyc);
            end
            if (done) begin
                done_cnt++; done_cyc = cyc; busy_at_done = busy;
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic clr_stats();
        wi_addr.delete(); wi_data.delete(); wi_cyc.delete();
        wd_addr.delete(); wd_data.delete(); dq.delete(); dq_cyc.delete();
        en_cnt = 0; first_en = -1; last_wr = -1; ovl = 0; rd_cnt = 0;
        done_cnt = 0; done_cyc = -1; stab_err = 0; stall_cnt = 0; busy_cnt = 0;
        busy_at_done = 1'b0;
    endtask

    task automatic fill_rand(input int n);
        stim_q.delete();
        repeat (n) stim_q.push_back({$urandom, $urandom});
    endtask

    // Reference model: k-th imem word lands at 4k (low 32 bits), k-th dmem
    // word at 8k, and the dump returns the dmem words in order.
    function automatic int sb_errs(input int ni, input int nd);
        int e = 0;
        if (wi_addr.size() != ni) e++;
        if (wd_addr.size() != nd) e++;
        if (dq.size() != nd) e++;
        for (int k = 0; k < ni && k < wi_addr.size(); k++) begin
            if (wi_addr[k] !== 64'(4 * k)) e++;
            if (wi_data[k] !== stim_q[k][31:0]) e++;
        end
        for (int k = 0; k < nd && k < wd_addr.size(); k++) begin
            if (wd_addr[k] !== 64'(8 * k)) e++;
            if (wd_data[k] !== stim_q[ni + k]) e++;
        end
        for (int k = 0; k < nd && k < dq.size(); k++)
            if (dq[k] !== stim_q[ni + k]) e++;
        return e;
    endfunction

    // Runs one job. vmode: 0 valid high, 1 toggling, 2 random.
    // rmode: 0 ready high, 1 ready low for 4 cycles at the first dump word, 2 random.
    // restart_at: cycle offset of an extra start pulse (all-zero fields), -1 for none.
    task automatic do_op(input int ni, input int nd, input logic [CW-1:0] nr,
                         input int vmode, input int rmode, input int restart_at, output bit to);
        int idx = 0;
        int post = 0;
        int hold = 4;
        bit fin = 0;
        clr_stats();
        to = 1;
        for (int c = 0; c < 20000; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (c == 0) begin
                start = 1'b1; imem_words = IW'(ni); dmem_words = DW'(nd);
                run_cycles = nr; start_cyc = cyc;
            end else if (c == restart_at) begin
                start = 1'b1; imem_words = '0; dmem_words = '0; run_cycles = '0;
            end
            if (idx < stim_q.size()) begin
                case (vmode)
                    0:       in_valid = 1'b1;
                    1:       in_valid = (c % 2) == 1;
                    default: in_valid = 1'($urandom_range(0, 1));
                endcase
                in_data = in_valid ? stim_q[idx] : {$urandom, $urandom};
            end else begin
                in_valid = 1'b0;
            end
            if (in_valid && in_ready) idx++;
            case (rmode)
                0: out_ready = 1'b1;
                1: begin
                    if (out_valid && hold > 0) begin out_ready = 1'b0; hold--; end
                    else out_ready = 1'b1;
                end
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (fin) begin
                post++;
                if (post >= 4) begin to = 0; break; end
            end else if (done_cnt > 0) begin
                fin = 1;
            end
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        #3;
        n_tests++;
        if (all_out !== '0) begin n_fail++; $display("FAIL reset_outputs: got %0h want 0", all_out); end
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (all_out !== '0) begin n_fail++; $display("FAIL reset_held: got %0h want 0", all_out); end
        @(negedge clk); arst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({busy, in_ready, done} !== 3'b000) begin
            n_fail++; $display("FAIL idle_after_reset: busy/in_ready/done %b want 000", {busy, in_ready, done});
        end
    endtask

    task automatic test_directed();
        bit to;
        stim_q.delete();
        stim_q.push_back(64'h0000_0000_0000_0013);
        stim_q.push_back(64'h0000_0000_0010_0093);
        stim_q.push_back(64'h0000_0000_0020_0113);
        stim_q.push_back(64'h0000_0000_0000_000A);
        stim_q.push_back(64'h0000_0000_0000_000B);
        do_op(3, 2, 0, 0, 0, -1, to);
        n_tests++;
        if (to) begin n_fail++; $display("FAIL directed_timeout: no done seen"); end
        n_tests++;
        if (sb_errs(3, 2) !== 0) begin n_fail++; $display("FAIL directed_data: %0d errors want 0", sb_errs(3, 2)); end
        n_tests++;
        if ((wi_cyc.size() == 3 ? wi_cyc[2] - wi_cyc[0] : -1) !== 2) begin
            n_fail++; $display("FAIL directed_b2b_writes: span %0d want 2", wi_cyc.size() == 3 ? wi_cyc[2] - wi_cyc[0] : -1);
        end
        n_tests++;
        if ((dq_cyc.size() == 2 ? dq_cyc[1] - dq_cyc[0] : -1) !== 3) begin
            n_fail++; $display("FAIL directed_dump_rate: spacing %0d want 3", dq_cyc.size() == 2 ? dq_cyc[1] - dq_cyc[0] : -1);
        end
        n_tests++;
        if ({en_cnt, rd_cnt, done_cnt} !== {32'd0, 32'd2, 32'd1}) begin
            n_fail++; $display("FAIL directed_counts: en %0d rd %0d done %0d want 0 2 1", en_cnt, rd_cnt, done_cnt);
        end
    endtask

    task automatic test_run();
        bit to;
        int ni = $urandom_range(1, 8);
        int nd = $urandom_range(1, 8);
        fill_rand(ni + nd);
        do_op(ni, nd, 5, 0, 0, -1, to);
        n_tests++;
        if (to) begin n_fail++; $display("FAIL run_timeout: no done seen"); end
        n_tests++;
        if (en_cnt !== 5) begin n_fail++; $display("FAIL run_enable_cycles: got %0d want 5", en_cnt); end
        n_tests++;
        if (ovl !== 0) begin n_fail++; $display("FAIL run_exclusive: %0d overlap cycles want 0", ovl); end
        n_tests++;
        if (!(first_en - last_wr >= 1)) begin
            n_fail++; $display("FAIL run_gap: first enable %0d last write %0d want enable later", first_en, last_wr);
        end
        n_tests++;
        if (sb_errs(ni, nd) !== 0) begin n_fail++; $display("FAIL run_data: %0d errors want 0", sb_errs(ni, nd)); end
    endtask

    task automatic test_backpressure();
        bit to;
        int ni = $urandom_range(4, 10);
        int nd = $urandom_range(3, 6);
        fill_rand(ni + nd);
        do_op(ni, nd, 3, 1, 1, -1, to);
        n_tests++;
        if (to) begin n_fail++; $display("FAIL bp_timeout: no done seen"); end
        n_tests++;
        if (sb_errs(ni, nd) !== 0) begin n_fail++; $display("FAIL bp_data: %0d errors want 0", sb_errs(ni, nd)); end
        n_tests++;
        if (stab_err !== 0) begin n_fail++; $display("FAIL bp_out_stable: %0d unstable cycles want 0", stab_err); end
        n_tests++;
        if (stall_cnt !== 4) begin n_fail++; $display("FAIL bp_stalls: got %0d want 4", stall_cnt); end
        n_tests++;
        if ({ovl, en_cnt} !== {32'd0, 32'd3}) begin
            n_fail++; $display("FAIL bp_run: overlap %0d enable %0d want 0 3", ovl, en_cnt);
        end
    endtask

    task automatic test_boundary();
        bit to;
        fill_rand(511 + 1023);
        do_op(511, 1023, 0, 0, 0, -1, to);
        n_tests++;
        if (to) begin n_fail++; $display("FAIL bound_timeout: no done seen"); end
        n_tests++;
        if ((wi_addr.size() > 0 ? wi_addr[wi_addr.size() - 1] : 64'hX) !== 64'h7F8) begin
            n_fail++; $display("FAIL bound_imem_last_addr: got %0h want 7f8", wi_addr.size() > 0 ? wi_addr[wi_addr.size() - 1] : 64'h0);
        end
        n_tests++;
        if ((wd_addr.size() > 0 ? wd_addr[wd_addr.size() - 1] : 64'hX) !== 64'h1FF0) begin
            n_fail++; $display("FAIL bound_dmem_last_addr: got %0h want 1ff0", wd_addr.size() > 0 ? wd_addr[wd_addr.size() - 1] : 64'h0);
        end
        n_tests++;
        if (dq.size() !== 1023) begin n_fail++; $display("FAIL bound_dump_count: got %0d want 1023", dq.size()); end
        n_tests++;
        if (sb_errs(511, 1023) !== 0) begin n_fail++; $display("FAIL bound_data: %0d errors want 0", sb_errs(511, 1023)); end
    endtask

    task automatic test_zero();
        bit to;
        stim_q.delete();
        // Extra start lands in the FIN cycle and must be ignored.
        do_op(0, 0, 0, 0, 0, 2, to);
        n_tests++;
        if (to) begin n_fail++; $display("FAIL zero_timeout: no done seen"); end
        n_tests++;
        if (done_cyc - start_cyc !== 2) begin
            n_fail++; $display("FAIL zero_latency: done at start+%0d want start+2", done_cyc - start_cyc);
        end
        n_tests++;
        if (wi_addr.size() + wd_addr.size() + rd_cnt + en_cnt !== 0) begin
            n_fail++; $display("FAIL zero_no_pulses: got %0d pulses want 0", wi_addr.size() + wd_addr.size() + rd_cnt + en_cnt);
        end
        n_tests++;
        if (done_cnt !== 1) begin n_fail++; $display("FAIL zero_fin_start: done count %0d want 1", done_cnt); end
        n_tests++;
        if ({busy_cnt, 31'd0, busy_at_done} !== {32'd1, 32'd0}) begin
            n_fail++; $display("FAIL zero_busy: busy cycles %0d busy at done %0d want 1 0", busy_cnt, busy_at_done);
        end
    endtask

    task automatic test_start_ignored();
        bit to;
        fill_rand(10);
        do_op(6, 4, 2, 0, 0, 3, to);
        n_tests++;
        if (to) begin n_fail++; $display("FAIL midstart_timeout: no done seen"); end
        n_tests++;
        if (sb_errs(6, 4) !== 0) begin n_fail++; $display("FAIL midstart_data: %0d errors want 0", sb_errs(6, 4)); end
        n_tests++;
        if ({done_cnt, en_cnt} !== {32'd1, 32'd2}) begin
            n_fail++; $display("FAIL midstart_counts: done %0d enable %0d want 1 2", done_cnt, en_cnt);
        end
    endtask

    task automatic test_reset_mid_run();
        bit to;
        bit seen = 0;
        int idx = 0;
        fill_rand(4);
        clr_stats();
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (cpu_enable) begin seen = 1; break; end
            start = (c == 0);
            if (c == 0) begin imem_words = 2; dmem_words = 2; run_cycles = 40; end
            in_valid = idx < stim_q.size();
            in_data = in_valid ? stim_q[idx] : 64'h0;
            if (in_valid && in_ready) idx++;
        end
        start = 1'b0; in_valid = 1'b0;
        n_tests++;
        if (!seen) begin n_fail++; $display("FAIL rstrun_reach_run: cpu_enable never seen"); end
        #2 arst_n = 1'b0;
        #1;
        n_tests++;
        if (all_out !== '0) begin n_fail++; $display("FAIL rstrun_outputs: got %0h want 0", all_out); end
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        fill_rand(6);
        do_op(3, 3, 4, 2, 2, -1, to);
        n_tests++;
        if (to) begin n_fail++; $display("FAIL rstrun_fresh_timeout: no done seen"); end
        n_tests++;
        if (sb_errs(3, 3) !== 0) begin n_fail++; $display("FAIL rstrun_fresh_data: %0d errors want 0", sb_errs(3, 3)); end
        n_tests++;
        if ({en_cnt, done_cnt} !== {32'd4, 32'd1}) begin
            n_fail++; $display("FAIL rstrun_fresh_counts: enable %0d done %0d want 4 1", en_cnt, done_cnt);
        end
    endtask

    task automatic test_random();
        bit to;
        for (int it = 0; it < 5; it++) begin
            int ni = $urandom_range(0, 12);
            int nd = $urandom_range(0, 12);
            int nr = $urandom_range(0, 6);
            fill_rand(ni + nd);
            do_op(ni, nd, CW'(nr), 2, 2, -1, to);
            n_tests++;
            if (to) begin n_fail++; $display("FAIL rand%0d_timeout: no done seen", it); end
            n_tests++;
            if (sb_errs(ni, nd) !== 0) begin n_fail++; $display("FAIL rand%0d_data: %0d errors want 0", it, sb_errs(ni, nd)); end
            n_tests++;
            if ({en_cnt, ovl, stab_err, done_cnt} !== {nr, 32'd0, 32'd0, 32'd1}) begin
                n_fail++;
                $display("FAIL rand%0d_ctrl: enable %0d overlap %0d unstable %0d done %0d want %0d 0 0 1",
                         it, en_cnt, ovl, stab_err, done_cnt, nr);
            end
        end
    endtask

    initial begin
        clr_stats();
        test_reset();
        test_directed();
        test_run();
        test_backpressure();
        test_boundary();
        test_zero();
        test_start_ignored();
        test_reset_mid_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
